debounced_bcd_counter: RTL

Four-digit BCD up/down event counter driven by raw push-button inputs. It synchronises and debounces each button and counts clean presses modulo 10000. It drives per-digit active-high segment enables straight into the team's hex display stage. That stage performs the active-low inversion and pin reordering; this block performs neither.

---
 rtl/debounced_bcd_counter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/debounced_bcd_counter.sv
// Four-digit BCD up/down event counter fed by raw push buttons.
// Each button is synchronised, debounced and edge-detected; clean presses
// step a modulo-10000 BCD count whose digits drive active-high segment
// enables (bit0=a .. bit3=d, bit4=f, bit5=g, bit6=e) for the hex stage.

module debounced_bcd_counter_btn #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        acc;
  logic [23:0] db_cnt;

  // Two-flop synchroniser, mismatch-counting debouncer and rising-edge pulse.
  // The pulse is registered on the same edge the accepted level rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      acc    <= 1'b0;
      db_cnt <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        acc    <= ~acc;
        db_cnt <= '0;
        pulse  <= ~acc;
      end else begin
        db_cnt <= db_cnt + 24'd1;
      end
    end
  end

endmodule

module debounced_bcd_counter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_LZ        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic        wrap
);

  localparam logic BLANK = (BLANK_LZ != 0);
  localparam logic [6:0] SEG_RST_UPPER = BLANK ? 7'h00 : 7'h5F;

  logic        inc_p;
  logic        dec_p;
  logic [15:0] cnt_next;
  logic        wrap_next;
  logic        blank1;
  logic        blank2;
  logic        blank3;

  debounced_bcd_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .pulse (inc_p)
  );

  debounced_bcd_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dec),
    .pulse (dec_p)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h5F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h6B;
      4'd3:    g = 7'h2F;
      4'd4:    g = 7'h36;
      4'd5:    g = 7'h3D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h3F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Next count and wrap flag; clr beats simultaneous pulses, which cancel.
  always_comb begin
    cnt_next  = count_bcd;
    wrap_next = 1'b0;
    if (clr) begin
      cnt_next = 16'h0000;
    end else if (inc_p && dec_p) begin
      cnt_next = count_bcd;
    end else if (inc_p) begin
      cnt_next  = bcd_inc(count_bcd);
      wrap_next = (count_bcd == 16'h9999);
    end else if (dec_p) begin
      cnt_next  = bcd_dec(count_bcd);
      wrap_next = (count_bcd == 16'h0000);
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_bcd <= 16'h0000;
      wrap      <= 1'b0;
    end else begin
      count_bcd <= cnt_next;
      wrap      <= wrap_next;
    end
  end

  // Leading-zero blanking looks only at the digits above each position,
  // so interior zeros stay lit.
  always_comb begin
    blank3 = BLANK && (count_bcd[15:12] == 4'd0);
    blank2 = blank3 && (count_bcd[11:8] == 4'd0);
    blank1 = blank2 && (count_bcd[7:4] == 4'd0);
  end

  // Segment registers, one edge behind count_bcd.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg0 <= 7'h5F;
      seg1 <= SEG_RST_UPPER;
      seg2 <= SEG_RST_UPPER;
      seg3 <= SEG_RST_UPPER;
    end else begin
      seg0 <= glyph(count_bcd[3:0]);
      seg1 <= blank1 ? 7'h00 : glyph(count_bcd[7:4]);
      seg2 <= blank2 ? 7'h00 : glyph(count_bcd[11:8]);
      seg3 <= blank3 ? 7'h00 : glyph(count_bcd[15:12]);
    end
  end

endmodule
